// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access widths and FSM states.
package dmem_pkg;

  localparam logic [1:0] WIDTH_B = 2'b00;
  localparam logic [1:0] WIDTH_H = 2'b01;
  localparam logic [1:0] WIDTH_W = 2'b10;
  localparam logic [1:0] WIDTH_X = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for one access: write enables and merge on the store side,
// lane select and sign/zero extension on the load side.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic [1:0]  width,
  input  logic [31:0] wdata,
  input  logic        sign_extend,
  input  logic [31:0] word,
  output logic [3:0]  be,
  output logic [31:0] merged,
  output logic [31:0] rdata,
  output logic        misalign
);

  logic [31:0] wide;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = addr[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    be       = 4'b0000;
    wide     = wdata;
    rdata    = 32'h0;
    misalign = 1'b0;
    case (width)
      WIDTH_B: begin
        be    = 4'b0001 << addr;
        wide  = {4{wdata[7:0]}};
        rdata = sign_extend ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
      end
      WIDTH_H: begin
        misalign = addr[0];
        be       = addr[1] ? 4'b1100 : 4'b0011;
        wide     = {2{wdata[15:0]}};
        rdata    = sign_extend ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
      end
      WIDTH_W: begin
        misalign = |addr;
        be       = 4'b1111;
        rdata    = word;
      end
      default: begin
        be    = 4'b0000;
        rdata = 32'h0;
      end
    endcase
  end

  // Replicated store data lets every lane pick its byte without a shifter.
  always_comb begin
    merged = word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = wide[8*i +: 8];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding request, fixed-latency response,
// store commit and load capture both happen at the accept edge.
//
// state | meaning
// IDLE  | ready for a request; accept on req_valid_i & req_ready_o
// WAIT  | latency down-counter running; leaves at terminal count 0
// RESP  | response presented and held until rsp_ready_i
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  req_width_i,
  input  logic        req_write_i,
  input  logic        req_sign_extend_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int          IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_L  = 32'(DEPTH_WORDS);
  localparam logic [3:0]  LAT_LOAD = 4'(LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        live_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic             accept;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic [31:0]      word_rd;
  logic [3:0]       be;
  logic [31:0]      merged;
  logic [31:0]      load_data;
  logic             misalign;
  logic             err;

  assign accept   = req_valid_i & req_ready_o;
  assign in_range = {2'b00, req_addr_i[31:2]} < DEPTH_L;
  assign idx      = req_addr_i[IDX_W+1:2];
  assign word_rd  = in_range ? mem[idx] : 32'h0;
  assign err      = (req_width_i == WIDTH_X) | misalign | ~in_range;

  dmem_lane_align u_align (
    .addr        (req_addr_i[1:0]),
    .width       (req_width_i),
    .wdata       (req_wdata_i),
    .sign_extend (req_sign_extend_i),
    .word        (word_rd),
    .be          (be),
    .merged      (merged),
    .rdata       (load_data),
    .misalign    (misalign)
  );

  // Array has no reset: contents survive rst_i.
  always_ff @(posedge clk_i) begin
    if (accept && req_write_i && !err && (be != 4'b0000)) begin
      mem[idx] <= merged;
    end
  end

  // live_q keeps ready low until the first edge after reset release.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      live_q  <= 1'b1;
    end
  end

  // Every accept passes through WAIT, so the response appears LATENCY edges
  // after the accept edge for all legal latencies, including 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = LAT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else if (accept) begin
      rdata_q <= (err || req_write_i) ? 32'h0 : load_data;
      err_q   <= err;
    end else if (state_q == RESP && rsp_ready_i) begin
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end
  end

  assign req_ready_o = live_q && (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder against a byte-array memory model.
module tb_dmem_responder;

  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_width = '0;
  logic        req_write = 1'b0;
  logic        req_sext = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] mbytes [0:4*DEPTH-1];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk_i             (clk),
    .rst_i             (rst_n),
    .req_valid_i       (req_valid),
    .req_ready_o       (req_ready),
    .req_addr_i        (req_addr),
    .req_wdata_i       (req_wdata),
    .req_width_i       (req_width),
    .req_write_i       (req_write),
    .req_sign_extend_i (req_sext),
    .rsp_valid_o       (rsp_valid),
    .rsp_ready_i       (rsp_ready),
    .rsp_rdata_o       (rsp_rdata),
    .rsp_err_o         (rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic model_err(input logic [1:0] w, input logic [31:0] a);
    if (w == 2'b11) return 1'b1;
    if (w == 2'b01 && a[0]) return 1'b1;
    if (w == 2'b10 && a[1:0] != 2'b00) return 1'b1;
    if ((a >> 2) >= 32'(DEPTH)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] w, input logic [31:0] a, input logic s);
    logic [7:0]  b;
    logic [15:0] h;
    case (w)
      2'b00: begin
        b = mbytes[a];
        return s ? {{24{b[7]}}, b} : {24'h0, b};
      end
      2'b01: begin
        h = {mbytes[a+1], mbytes[a]};
        return s ? {{16{h[15]}}, h} : {16'h0, h};
      end
      default: return {mbytes[a+3], mbytes[a+2], mbytes[a+1], mbytes[a]};
    endcase
  endfunction

  task automatic model_store(input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
    int n;
    n = (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
    for (int i = 0; i < n; i++) mbytes[a + 32'(i)] = d[8*i +: 8];
  endtask

  task automatic xact(input string tag, input logic wr, input logic [1:0] w, input logic [31:0] a,
                      input logic [31:0] d, input logic s, input int hold,
                      output logic [31:0] got, output logic got_err);
    logic        exp_err;
    logic [31:0] exp_data;
    int          n;
    int          lat;
    exp_err  = model_err(w, a);
    exp_data = (wr || exp_err) ? 32'h0 : model_load(w, a, s);
    got      = 32'hX;
    got_err  = 1'bX;
    @(negedge clk);
    req_addr  = a;
    req_wdata = d;
    req_width = w;
    req_write = wr;
    req_sext  = s;
    req_valid = 1'b1;
    rsp_ready = (hold == 0);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, " req_ready"}, 32'(req_ready), 32'd1);
    if (!req_ready) begin
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      return;
    end
    @(posedge clk);
    if (wr && !exp_err) model_store(w, a, d);
    #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_width = 2'($urandom_range(0, 3));
    req_write = 1'($urandom_range(0, 1));
    req_sext  = 1'($urandom_range(0, 1));
    check({tag, " busy"}, 32'(req_ready), 32'd0);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) begin
        lat = i;
        break;
      end
    end
    check({tag, " latency"}, 32'(lat), 32'(LAT));
    got     = rsp_rdata;
    got_err = rsp_err;
    check({tag, " rdata"}, rsp_rdata, exp_data);
    check({tag, " err"}, 32'(rsp_err), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, " hold valid"}, 32'(rsp_valid), 32'd1);
      check({tag, " hold rdata"}, rsp_rdata, exp_data);
      check({tag, " hold err"}, 32'(rsp_err), 32'(exp_err));
      check({tag, " hold ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, " done valid"}, 32'(rsp_valid), 32'd0);
    check({tag, " done ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] got;
    logic        gerr;
    logic [31:0] prior;
    logic [1:0]  w;
    logic [31:0] a;

    #1;
    check("rst ready", 32'(req_ready), 32'd0);
    check("rst valid", 32'(rsp_valid), 32'd0);
    check("rst rdata", rsp_rdata, 32'd0);
    check("rst err", 32'(rsp_err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel ready before edge", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    check("rel ready after edge", 32'(req_ready), 32'd1);

    for (int i = 0; i < DEPTH; i++) xact("fill", 1'b1, 2'b10, 32'(4 * i), $urandom, 1'b0, 0, got, gerr);

    xact("st_w 0x10", 1'b1, 2'b10, 32'h10, 32'h12345678, 1'b0, 0, got, gerr);
    xact("ld_w 0x10", 1'b0, 2'b10, 32'h10, 32'h0, 1'b0, 0, got, gerr);
    check("ld_w 0x10 lit", got, 32'h12345678);

    xact("st_b 0x11", 1'b1, 2'b00, 32'h11, 32'h000000AB, 1'b0, 0, got, gerr);
    xact("ld_b 0x11 s", 1'b0, 2'b00, 32'h11, 32'h0, 1'b1, 0, got, gerr);
    check("ld_b 0x11 s lit", got, 32'hFFFFFFAB);
    xact("ld_b 0x11 u", 1'b0, 2'b00, 32'h11, 32'h0, 1'b0, 0, got, gerr);
    check("ld_b 0x11 u lit", got, 32'h000000AB);
    xact("ld_w merged", 1'b0, 2'b10, 32'h10, 32'h0, 1'b0, 0, got, gerr);
    check("ld_w merged lit", got, 32'h1234AB78);

    xact("st_w half src", 1'b1, 2'b10, 32'h10, 32'h80017FFF, 1'b0, 0, got, gerr);
    xact("ld_h 0x12 s", 1'b0, 2'b01, 32'h12, 32'h0, 1'b1, 0, got, gerr);
    check("ld_h 0x12 s lit", got, 32'hFFFF8001);
    xact("ld_h 0x10 s", 1'b0, 2'b01, 32'h10, 32'h0, 1'b1, 0, got, gerr);
    check("ld_h 0x10 s lit", got, 32'h00007FFF);

    xact("ld prior 0x20", 1'b0, 2'b10, 32'h20, 32'h0, 1'b0, 0, prior, gerr);
    xact("st_w mis 0x22", 1'b1, 2'b10, 32'h22, 32'hDEADBEEF, 1'b0, 0, got, gerr);
    check("st_w mis err lit", 32'(gerr), 32'd1);
    xact("st_w oor", 1'b1, 2'b10, 32'(4 * DEPTH), 32'hDEADBEEF, 1'b0, 0, got, gerr);
    check("st_w oor err lit", 32'(gerr), 32'd1);
    xact("st w11", 1'b1, 2'b11, 32'h20, 32'hDEADBEEF, 1'b0, 0, got, gerr);
    check("st w11 err lit", 32'(gerr), 32'd1);
    xact("ld after bad st", 1'b0, 2'b10, 32'h20, 32'h0, 1'b0, 0, got, gerr);
    check("ld after bad st lit", got, prior);

    xact("stall", 1'b0, 2'b10, 32'h10, 32'h0, 1'b0, 5, got, gerr);

    @(negedge clk);
    req_addr  = 32'h40;
    req_wdata = 32'hCAFEF00D;
    req_width = 2'b10;
    req_write = 1'b1;
    req_sext  = 1'b0;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    check("midrst ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    model_store(2'b10, 32'h40, 32'hCAFEF00D);
    #1 req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst valid", 32'(rsp_valid), 32'd0);
    check("midrst ready low", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst ready after", 32'(req_ready), 32'd1);
    check("midrst valid after", 32'(rsp_valid), 32'd0);
    xact("ld 0x40", 1'b0, 2'b10, 32'h40, 32'h0, 1'b0, 0, got, gerr);
    check("ld 0x40 lit", got, 32'hCAFEF00D);

    repeat (300) begin
      w = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a = ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, 4 * DEPTH + 7));
      xact("rand", 1'($urandom_range(0, 1)), w, a, $urandom, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0, got, gerr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
